ahb_ram_slave: RTL and testbench

//  AHB-Lite subordinate: word-organised RAM on the shared bus; the multicycle ARM core's bus master is the initiator.

---
 rtl/ahb_ram_slave_if.sv | 26 ++
 rtl/ahb_ram_slave.sv | 112 +++++++++++
 tb/tb_ahb_ram_slave.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite bus bundle between the core's master and the RAM subordinate.
// HREADY is the interconnect's combined ready and is driven from the master side.
interface ahb_ram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ram_slave.sv
// AHB-Lite word RAM subordinate with programmable wait states
// and a two-cycle ERROR response for misaligned or oversized accesses.
module ahb_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       reset,
  ahb_ram_slave_if.slave bus
);
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [2:0]      size_q, size_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [31:0]     mem [2**ADDR_WIDTH];

  logic            accept;
  logic            bad;
  logic            final_c;
  logic            take;
  logic            we;
  logic [3:0]      be;
  logic [ADDR_WIDTH-1:0] widx;
  logic            unused_bits;

  assign unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign bad = (bus.HSIZE > 3'b010)
             | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
             | ((bus.HSIZE == 3'b010) & (bus.HADDR[1:0] != 2'b00));

  assign final_c = (state_q == S_DATA) && (cnt_q == 4'd0);
  // New address phases are only taken when no data phase is stalling
  assign take = accept && ((state_q == S_IDLE) || final_c);
  assign we = final_c && wr_q;
  assign widx = addr_q[AW-1:2];

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size_q == 3'b000: be = 4'b0001 << addr_q[1:0];
      size_q == 3'b001: be = addr_q[1] ? 4'b1100 : 4'b0011;
      size_q == 3'b010: be = 4'b1111;
      default:          be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    if (take) begin
      addr_d  = bus.HADDR[AW-1:0];
      wr_d    = bus.HWRITE;
      size_d  = bus.HSIZE;
      cnt_d   = WS;
      state_d = bad ? S_ERR1 : S_DATA;
    end else begin
      case (state_q)
        S_DATA: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else state_d = S_IDLE;
        end
        S_ERR1:  state_d = S_ERR2;
        S_ERR2:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 3'b000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[widx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
  end

  assign bus.HREADYOUT = !((state_q == S_DATA) && (cnt_q != 4'd0))
                       && (state_q != S_ERR1);
  assign bus.HRESP  = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.HRDATA = (final_c && !wr_q) ? mem[widx] : 32'h0;
endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: a zero-wait and a
// two-wait instance share one stimulus driver, selected by `which`.
module tb_ahb_ram_slave;
  logic clk;
  logic reset;
  logic which;

  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;

  logic        rdy_o;
  logic        resp_o;
  logic [31:0] rdata_o;

  logic        o_rdy;
  logic        o_resp;
  logic [31:0] o_rdata;

  logic        rd_ph;
  logic [31:0] cur_wd;
  logic [31:0] exp_q[$];

  int n_run;
  int n_fail;
  int lows;

  ahb_ram_slave_if b0 ();
  ahb_ram_slave_if b2 ();

  assign b0.HSEL   = hsel & !which;
  assign b2.HSEL   = hsel & which;
  assign b0.HTRANS = htrans;
  assign b2.HTRANS = htrans;
  assign b0.HWRITE = hwrite;
  assign b2.HWRITE = hwrite;
  assign b0.HSIZE  = hsize;
  assign b2.HSIZE  = hsize;
  assign b0.HADDR  = haddr;
  assign b2.HADDR  = haddr;
  assign b0.HWDATA = hwdata;
  assign b2.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b2.HREADY = b2.HREADYOUT;

  assign rdy_o   = which ? b2.HREADYOUT : b0.HREADYOUT;
  assign resp_o  = which ? b2.HRESP : b0.HRESP;
  assign rdata_o = which ? b2.HRDATA : b0.HRDATA;

  ahb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  ahb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive address phase, sample at negedge, score.
  task automatic step(input logic s, input logic [1:0] t,
                      input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic [31:0] ex);
    hsel = s; htrans = t; hwrite = w;
    hsize = sz; haddr = a; hwdata = cur_wd;
    @(negedge clk);
    o_rdy = rdy_o; o_resp = resp_o; o_rdata = rdata_o;
    if (o_rdy && rd_ph) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("rdata", o_rdata, exp_q.pop_front());
    end else begin
      chk("rdata_zero", o_rdata, 32'd0);
    end
    if (o_rdy) begin
      rd_ph = s && t[1] && rd;
      if (rd_ph) exp_q.push_back(ex);
      cur_wd = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic [31:0] ex,
                       output int nlow);
    logic acc;
    acc = 1'b0;
    nlow = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      step(1'b1, 2'b10, w, sz, a, wd, rd, ex);
      if (o_rdy) acc = 1'b1;
      else nlow++;
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic [31:0] wd);
    step(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, wd, 1'b0, 32'h0);
  endtask

  task automatic drain(output int nlow);
    logic done;
    done = 1'b0;
    nlow = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      idle(32'h0);
      if (o_rdy) done = 1'b1;
      else nlow++;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic err_seq(input string tag);
    idle(32'h0);
    chk({tag, "_c1_rdy"}, {31'd0, o_rdy}, 32'd0);
    chk({tag, "_c1_resp"}, {31'd0, o_resp}, 32'd1);
    idle(32'h0);
    chk({tag, "_c2_rdy"}, {31'd0, o_rdy}, 32'd1);
    chk({tag, "_c2_resp"}, {31'd0, o_resp}, 32'd1);
    idle(32'h0);
    chk({tag, "_ok_rdy"}, {31'd0, o_rdy}, 32'd1);
    chk({tag, "_ok_resp"}, {31'd0, o_resp}, 32'd0);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    which = 1'b0; reset = 1'b0;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; haddr = 32'h0; hwdata = 32'h0;
    rd_ph = 1'b0; cur_wd = 32'h0;
    #3;
    chk("rst_rdy0", {31'd0, b0.HREADYOUT}, 32'd1);
    chk("rst_resp0", {31'd0, b0.HRESP}, 32'd0);
    chk("rst_rdata0", b0.HRDATA, 32'd0);
    chk("rst_rdy2", {31'd0, b2.HREADYOUT}, 32'd1);
    chk("rst_resp2", {31'd0, b2.HRESP}, 32'd0);
    chk("rst_rdata2", b2.HRDATA, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(32'h0);

    // zero-wait write then pipelined read
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, lows);
    chk("t2_wr_nostall", lows, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, lows);
    chk("t2_rd_nostall", lows, 0);
    drain(lows);
    chk("t2_data_nostall", lows, 0);

    // byte and half lane merges
    issue(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0, lows);
    issue(1'b1, 3'b000, 32'h13, 32'hA5000000, 1'b0, 32'h0, lows);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hA5223344, lows);
    issue(1'b1, 3'b001, 32'h10, 32'h0000BEEF, 1'b0, 32'h0, lows);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hA522BEEF, lows);
    drain(lows);

    // read then write to same word sees old data
    issue(1'b1, 3'b010, 32'h20, 32'h00001111, 1'b0, 32'h0, lows);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h00001111, lows);
    issue(1'b1, 3'b010, 32'h20, 32'h00002222, 1'b0, 32'h0, lows);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h00002222, lows);
    drain(lows);

    // error responses
    issue(1'b0, 3'b010, 32'h02, 32'h0, 1'b0, 32'h0, lows);
    err_seq("mis_rd");
    issue(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0, lows);
    err_seq("size3");
    issue(1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 1'b0, 32'h0, lows);
    err_seq("mis_half");
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hA522BEEF, lows);
    drain(lows);

    // IDLE transfer and deselected NONSEQ do nothing
    step(1'b1, 2'b00, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b10, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("t6_idle_rdy", {31'd0, o_rdy}, 32'd1);
    chk("t6_idle_resp", {31'd0, o_resp}, 32'd0);
    idle(32'h0);
    chk("t6_desel_rdy", {31'd0, o_rdy}, 32'd1);
    chk("t6_desel_resp", {31'd0, o_resp}, 32'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hA522BEEF, lows);
    drain(lows);

    // address aliasing above 4*depth
    issue(1'b1, 3'b010, 32'h1010, 32'hCAFEF00D, 1'b0, 32'h0, lows);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D, lows);
    drain(lows);
    idle(32'h0);

    // two wait states
    which = 1'b1;
    idle(32'h0);
    issue(1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0, 32'h0, lows);
    chk("t4_wr_first", lows, 0);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h12345678, lows);
    chk("t4_rd_holdoff", lows, 2);
    drain(lows);
    chk("t4_rd_waits", lows, 2);
    idle(32'h0);

    // reset in the middle of a waited write
    issue(1'b1, 3'b010, 32'h40, 32'hAAAAAAAA, 1'b0, 32'h0, lows);
    hsel = 1'b0; htrans = 2'b00; hwdata = cur_wd;
    #3;
    chk("t1_midwait_rdy", {31'd0, rdy_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("t1_rst_rdy", {31'd0, rdy_o}, 32'd1);
    chk("t1_rst_resp", {31'd0, resp_o}, 32'd0);
    chk("t1_rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_ph = 1'b0; cur_wd = 32'h0;
    idle(32'h0);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h12345678, lows);
    drain(lows);
    idle(32'h0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
